// File: rtl/op_issue_pkg.sv
// Shared types for the operation issue controller: opcodes, controller states
// and default sizing.
package op_issue_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } state_e;

endpackage

// File: rtl/op_datapath.sv
// Combinational ALU slice: AND/OR/ADD/SUB with a carry or borrow flag.
module op_datapath
    import op_issue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Zero-extended subtraction leaves the borrow (a < b) in the top bit.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        flag   = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  {flag, result} = sum;
            OP_SUB:  {flag, result} = diff;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/op_issue_ctrl.sv
// Command FIFO feeding a single result register through the datapath, with
// valid/ready handshakes on both sides and a rolling 2-bit issue tag.
module op_issue_ctrl
    import op_issue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag,
    output logic [1:0]       rsp_tag,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    op_e              fifo_op [DEPTH];
    logic [WIDTH-1:0] fifo_a  [DEPTH];
    logic [WIDTH-1:0] fifo_b  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [1:0]       tag_cnt;
    state_e           state;
    state_e           state_nxt;

    logic             push;
    logic             issue;
    logic             fifo_empty;
    logic [WIDTH-1:0] dp_result;
    logic             dp_flag;

    // Readiness looks only at the occupancy count, never at a same-cycle pop.
    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign issue      = !fifo_empty && (!rsp_valid || rsp_ready);
    assign busy       = !fifo_empty || rsp_valid;

    op_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .op     (fifo_op[rd_ptr]),
        .a      (fifo_a[rd_ptr]),
        .b      (fifo_b[rd_ptr]),
        .result (dp_result),
        .flag   (dp_flag)
    );

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_op[wr_ptr] <= op_e'(cmd_op);
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tag_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // An issue refills the result register on the same edge it drains.
            if (issue) begin
                rsp_valid <= 1'b1;
                rsp_data  <= dp_result;
                rsp_flag  <= dp_flag;
                rsp_tag   <= tag_cnt;
                tag_cnt   <= tag_cnt + 2'd1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (push) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (rsp_valid && !rsp_ready && !fifo_empty) begin
                    state_nxt = ST_STALL;
                end else if (fifo_empty && !push && (!rsp_valid || rsp_ready)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (rsp_ready) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_op_issue_ctrl.sv
// Self-checking bench for op_issue_ctrl: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_op_issue_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_flag;
    logic [1:0]       rsp_tag;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             flag;
        logic [1:0]       tag;
    } exp_t;

    typedef struct {
        logic             valid;
        logic             drain;
        logic             accepted;
        logic             rdy_in;
        logic [WIDTH-1:0] data;
        logic             flag;
        logic [1:0]       tag;
        logic             busy;
        logic             ready;
        int               outstanding;
    } obs_t;

    exp_t exp_q[$];
    int   model_tag;
    int   checks;
    int   errors;

    op_issue_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic on plain integers, independent of bit tricks.
    function automatic exp_t ref_calc(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        int unsigned ia, ib, r, modv;
        exp_t e;
        ia     = a;
        ib     = b;
        modv   = 1 << WIDTH;
        e.flag = 1'b0;
        e.tag  = '0;
        case (op)
            2'd0:    r = ia & ib;
            2'd1:    r = ia | ib;
            2'd2:    begin r = ia + ib; e.flag = (r >= modv); end
            default: begin r = ia + modv - ib; e.flag = (ia < ib); end
        endcase
        r      = r % modv;
        e.data = WIDTH'(r);
        return e;
    endfunction

    task automatic model_push(input logic [1:0] op, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
        exp_t e;
        e     = ref_calc(op, a, b);
        e.tag = 2'(model_tag % 4);
        model_tag++;
        exp_q.push_back(e);
    endtask

    task automatic randomize_cmd();
        cmd_op = 2'($urandom_range(0, 3));
        cmd_a  = WIDTH'($urandom);
        cmd_b  = WIDTH'($urandom);
        if ($urandom_range(0, 7) == 0) cmd_a = '1;
        if ($urandom_range(0, 7) == 0) cmd_b = '0;
    endtask

    // Samples the DUT mid-cycle and records accepted commands in the model.
    task automatic clock_cycle(output obs_t o);
        @(negedge clk);
        o.valid       = rsp_valid;
        o.rdy_in      = rsp_ready;
        o.drain       = rsp_valid && rsp_ready;
        o.accepted    = cmd_valid && cmd_ready;
        o.data        = rsp_data;
        o.flag        = rsp_flag;
        o.tag         = rsp_tag;
        o.busy        = busy;
        o.ready       = cmd_ready;
        o.outstanding = exp_q.size();
        if (o.accepted) model_push(cmd_op, cmd_a, cmd_b);
        @(posedge clk);
        #1;
    endtask

    // Reset with live handshakes presented, which the DUT must ignore.
    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        randomize_cmd();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_q.delete();
        model_tag = 0;
    endtask

    task automatic test_reset();
        obs_t o;
        $display("[TB] test_reset");
        do_reset();
        clock_cycle(o);
        checks++;
        if (o.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", o.valid); end
        checks++;
        if (o.data !== '0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 00", o.data); end
        checks++;
        if (o.flag !== 1'b0 || o.tag !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_flag_tag: got %b/%0d expected 0/0", o.flag, o.tag);
        end
        checks++;
        if (o.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o.busy); end
        checks++;
        if (o.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", o.ready); end
        clock_cycle(o);
        checks++;
        if (o.valid !== 1'b0 || o.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ignored_push: got valid=%b busy=%b expected 0/0", o.valid, o.busy);
        end
    endtask

    task automatic test_add_latency();
        obs_t o;
        $display("[TB] test_add_latency");
        do_reset();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_a     = 8'hF0;
        cmd_b     = 8'h20;
        clock_cycle(o);
        checks++;
        if (o.accepted !== 1'b1) begin errors++; $display("[TB] FAIL add_accept: got %b expected 1", o.accepted); end
        cmd_valid = 1'b0;
        clock_cycle(o);
        checks++;
        if (o.valid !== 1'b0) begin errors++; $display("[TB] FAIL add_early: got rsp_valid %b expected 0", o.valid); end
        clock_cycle(o);
        checks++;
        if (o.valid !== 1'b1 || o.data !== 8'h10 || o.flag !== 1'b1 || o.tag !== 2'd0) begin
            errors++;
            $display("[TB] FAIL add_result: got v=%b d=%h f=%b t=%0d expected v=1 d=10 f=1 t=0",
                     o.valid, o.data, o.flag, o.tag);
        end
    endtask

    task automatic test_ops_back_to_back();
        obs_t o;
        logic [1:0]       ops [3];
        logic [WIDTH-1:0] as  [3];
        logic [WIDTH-1:0] bs  [3];
        logic [WIDTH-1:0] ed  [3];
        logic             ef  [3];
        int               k;
        int               first;
        $display("[TB] test_ops_back_to_back");
        ops[0] = 2'd3; as[0] = 8'h05; bs[0] = 8'h07; ed[0] = 8'hFE; ef[0] = 1'b1;
        ops[1] = 2'd0; as[1] = 8'hCC; bs[1] = 8'hAA; ed[1] = 8'h88; ef[1] = 1'b0;
        ops[2] = 2'd1; as[2] = 8'hCC; bs[2] = 8'hAA; ed[2] = 8'hEE; ef[2] = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        k     = 0;
        first = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 3) begin
                cmd_valid = 1'b1;
                cmd_op    = ops[cyc];
                cmd_a     = as[cyc];
                cmd_b     = bs[cyc];
            end else begin
                cmd_valid = 1'b0;
            end
            clock_cycle(o);
            if (o.drain && k < 3) begin
                if (first < 0) first = cyc;
                checks++;
                if (o.data !== ed[k] || o.flag !== ef[k] || o.tag !== 2'(k) || cyc != first + k) begin
                    errors++;
                    $display("[TB] FAIL op_seq_%0d: got d=%h f=%b t=%0d cyc=%0d expected d=%h f=%b t=%0d cyc=%0d",
                             k, o.data, o.flag, o.tag, cyc, ed[k], ef[k], k, first + k);
                end
                k++;
            end
        end
        checks++;
        if (k != 3) begin errors++; $display("[TB] FAIL op_seq_count: got %0d expected 3", k); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        int   acc;
        int   n;
        exp_t e;
        $display("[TB] test_backpressure");
        do_reset();
        rsp_ready = 1'b0;
        acc       = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            cmd_valid = 1'b1;
            randomize_cmd();
            clock_cycle(o);
            if (o.accepted) acc++;
            if (cyc >= 5) begin
                checks++;
                if (o.ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_cmd_ready_%0d: got %b expected 0", cyc, o.ready); end
            end
            if (cyc >= 2) begin
                checks++;
                if (o.valid !== 1'b1 || o.busy !== 1'b1 || o.data !== exp_q[0].data ||
                    o.flag !== exp_q[0].flag || o.tag !== 2'd0) begin
                    errors++;
                    $display("[TB] FAIL bp_hold_%0d: got v=%b b=%b d=%h f=%b t=%0d expected v=1 b=1 d=%h f=%b t=0",
                             cyc, o.valid, o.busy, o.data, o.flag, o.tag, exp_q[0].data, exp_q[0].flag);
                end
            end
        end
        checks++;
        if (acc != DEPTH + 1) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected %0d", acc, DEPTH + 1); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n         = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            clock_cycle(o);
            checks++;
            if (o.drain !== (cyc < DEPTH + 1)) begin
                errors++; $display("[TB] FAIL bp_drain_rate_%0d: got %b expected %b", cyc, o.drain, cyc < DEPTH + 1);
            end
            if (o.drain && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o.data !== e.data || o.flag !== e.flag || o.tag !== e.tag || o.tag !== 2'(n % 4)) begin
                    errors++;
                    $display("[TB] FAIL bp_drain_%0d: got d=%h f=%b t=%0d expected d=%h f=%b t=%0d",
                             n, o.data, o.flag, o.tag, e.data, e.flag, n % 4);
                end
                n++;
            end
        end
        checks++;
        if (exp_q.size() != 0 || o.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_leftover: got pending=%0d busy=%b expected 0/0", exp_q.size(), o.busy);
        end
    endtask

    task automatic test_reset_midop();
        obs_t o;
        $display("[TB] test_reset_midop");
        do_reset();
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            cmd_valid = 1'b1;
            randomize_cmd();
            clock_cycle(o);
        end
        cmd_valid = 1'b0;
        clock_cycle(o);
        checks++;
        if (o.valid !== 1'b1 || o.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL midop_before: got v=%b b=%b expected 1/1", o.valid, o.busy);
        end
        do_reset();
        rsp_ready = 1'b1;
        clock_cycle(o);
        checks++;
        if (o.valid !== 1'b0 || o.busy !== 1'b0 || o.ready !== 1'b1 || o.data !== '0) begin
            errors++;
            $display("[TB] FAIL midop_after: got v=%b b=%b r=%b d=%h expected 0/0/1/00", o.valid, o.busy, o.ready, o.data);
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            clock_cycle(o);
            checks++;
            if (o.valid !== 1'b0) begin errors++; $display("[TB] FAIL midop_stale_%0d: got rsp_valid %b expected 0", cyc, o.valid); end
        end
    endtask

    task automatic test_random_stream();
        obs_t o;
        exp_t e;
        int   n_acc;
        int   n_rsp;
        $display("[TB] test_random_stream");
        do_reset();
        rsp_ready = 1'b1;
        n_acc     = 0;
        n_rsp     = 0;
        cmd_valid = 1'b1;
        randomize_cmd();
        for (int cyc = 0; cyc < 400 && n_rsp < 100; cyc++) begin
            clock_cycle(o);
            checks++;
            if (o.busy !== (o.outstanding != 0)) begin
                errors++; $display("[TB] FAIL stream_busy_%0d: got %b expected %b", cyc, o.busy, o.outstanding != 0);
            end
            if (n_rsp > 0) begin
                checks++;
                if (o.drain !== 1'b1) begin errors++; $display("[TB] FAIL stream_gap_%0d: got drain %b expected 1", cyc, o.drain); end
            end
            if (o.drain) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL stream_spurious_%0d: got response d=%h expected none", cyc, o.data);
                end else begin
                    e = exp_q.pop_front();
                    if (o.data !== e.data || o.flag !== e.flag || o.tag !== e.tag) begin
                        errors++;
                        $display("[TB] FAIL stream_rsp_%0d: got d=%h f=%b t=%0d expected d=%h f=%b t=%0d",
                                 n_rsp, o.data, o.flag, o.tag, e.data, e.flag, e.tag);
                    end
                end
                n_rsp++;
            end
            if (o.accepted) begin
                n_acc++;
                randomize_cmd();
            end
            cmd_valid = (n_acc < 100);
        end
        checks++;
        if (n_rsp != 100) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 100", n_rsp); end
        cmd_valid = 1'b0;
    endtask

    task automatic test_random_backpressure();
        obs_t o;
        obs_t p;
        exp_t e;
        $display("[TB] test_random_backpressure");
        do_reset();
        p.valid  = 1'b0;
        p.rdy_in = 1'b1;
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (cyc < 300) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                rsp_ready = ($urandom_range(0, 3) != 0);
                randomize_cmd();
            end else begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            clock_cycle(o);
            if (p.valid && !p.rdy_in) begin
                checks++;
                if (o.valid !== 1'b1 || o.data !== p.data || o.flag !== p.flag || o.tag !== p.tag) begin
                    errors++;
                    $display("[TB] FAIL rbp_hold_%0d: got v=%b d=%h t=%0d expected v=1 d=%h t=%0d",
                             cyc, o.valid, o.data, o.tag, p.data, p.tag);
                end
            end
            if (o.drain) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL rbp_spurious_%0d: got response d=%h expected none", cyc, o.data);
                end else begin
                    e = exp_q.pop_front();
                    if (o.data !== e.data || o.flag !== e.flag || o.tag !== e.tag) begin
                        errors++;
                        $display("[TB] FAIL rbp_rsp_%0d: got d=%h f=%b t=%0d expected d=%h f=%b t=%0d",
                                 cyc, o.data, o.flag, o.tag, e.data, e.flag, e.tag);
                    end
                end
            end
            p = o;
        end
        clock_cycle(o);
        checks++;
        if (exp_q.size() != 0 || o.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL rbp_leftover: got pending=%0d busy=%b expected 0/0", exp_q.size(), o.busy);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        model_tag = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_latency();
        test_ops_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random_stream();
        test_random_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
